// File: rtl/isa_pkg.sv
// isa_pkg: opcode map, instruction field layout and sequencer state encoding.
package isa_pkg;
    localparam int INSTR_W = 24;
    localparam int ADDR_W  = 8;
    localparam int OP_HI = 23, OP_LO = 16;
    localparam int A_HI  = 15, A_LO  = 8;
    localparam int B_HI  = 7,  B_LO  = 0;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_JMP     = 8'h01;
    localparam logic [7:0] OP_JZ      = 8'h02;
    localparam logic [7:0] OP_JNZ     = 8'h03;
    localparam logic [7:0] OP_CALL    = 8'h04;
    localparam logic [7:0] OP_RET     = 8'h05;
    localparam logic [7:0] OP_RSV_MAX = 8'h0F;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_ISSUE, S_ADVANCE, S_JUMP, S_HALTED
    } state_t;

    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/return_stack.sv
// return_stack: small LIFO of return addresses with a combinational top entry.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [SPW-1:0] sp;
    // Sized to the pointer's range so the pointer indexes it without truncation.
    logic [W-1:0]   mem [2**SPW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sp <= '0;
        else if (push && !full) sp <= sp + 1'b1;
        else if (pop && !empty) sp <= sp - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[sp] <= data_in;
    end

    assign top   = mem[sp - 1'b1];
    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode FSM driving the program ROM; runs control flow
// locally and issues all other instructions to execute over valid/ready.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               zero_flag,
    input  logic               resume,
    output logic               pc_enable,
    output logic               jump_enable,
    output logic [ADDR_W-1:0]  jump_data,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [7:0]         issue_opcode,
    output logic [7:0]         issue_a,
    output logic [7:0]         issue_b,
    output logic [ADDR_W-1:0]  pc_mirror,
    output logic               halted,
    output logic               fault
);
    state_t              state, next;
    logic [INSTR_W-1:0]  ir;
    logic [ADDR_W-1:0]   jump_addr, tgt, stk_top;
    logic                push, pop, set_fault, stk_full, stk_empty;
    logic [7:0]          opc;

    assign opc = ir[OP_HI:OP_LO];

    return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .data_in (sat_inc(pc_mirror)),
        .top     (stk_top),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    always_comb begin
        next      = state;
        push      = 1'b0;
        pop       = 1'b0;
        set_fault = 1'b0;
        tgt       = ir[A_HI:A_LO];
        case (state)
            S_FETCH:   next = S_DECODE;
            S_DECODE: begin
                if (opc == OP_JMP) next = S_JUMP;
                else if (opc == OP_JZ) next = zero_flag ? S_JUMP : S_ADVANCE;
                else if (opc == OP_JNZ) next = zero_flag ? S_ADVANCE : S_JUMP;
                else if (opc == OP_CALL) begin
                    next      = stk_full ? S_HALTED : S_JUMP;
                    set_fault = stk_full;
                    push      = !stk_full;
                end else if (opc == OP_RET) begin
                    next      = stk_empty ? S_HALTED : S_JUMP;
                    set_fault = stk_empty;
                    pop       = !stk_empty;
                    tgt       = stk_top;
                end else if (opc == OP_HALT) next = S_HALTED;
                else next = (opc <= OP_RSV_MAX) ? S_ADVANCE : S_ISSUE;
            end
            S_ISSUE:   next = issue_ready ? S_ADVANCE : S_ISSUE;
            S_ADVANCE: next = S_FETCH;
            S_JUMP:    next = S_FETCH;
            S_HALTED:  next = (resume && !fault) ? S_ADVANCE : S_HALTED;
            default:   next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            ir        <= '0;
            pc_mirror <= '0;
            jump_addr <= '0;
            fault     <= 1'b0;
        end else begin
            state <= next;
            if (state == S_FETCH) ir <= instr_data;
            if (state == S_DECODE && next == S_JUMP) jump_addr <= tgt;
            if (set_fault) fault <= 1'b1;
            if (state == S_ADVANCE) pc_mirror <= sat_inc(pc_mirror);
            else if (state == S_JUMP) pc_mirror <= jump_addr;
        end
    end

    assign pc_enable    = (state == S_ADVANCE);
    assign jump_enable  = (state == S_JUMP);
    assign jump_data    = jump_addr;
    assign issue_valid  = (state == S_ISSUE);
    assign issue_opcode = ir[OP_HI:OP_LO];
    assign issue_a      = ir[A_HI:A_LO];
    assign issue_b      = ir[B_HI:B_LO];
    assign halted       = (state == S_HALTED);
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer: the consumer end of the program-ROM fetch interface. Each cycle it reads the 24-bit instruction word the ROM presents at its current PC and drives the ROM's `enable` (advance), `jump_enable` and `jump_data` (redirect) inputs. It executes control-flow opcodes itself (jumps, call/return on a small return stack, halt) and hands every other instruction to the execute stage over a valid/ready handshake.

## Interface
- `STACK_DEPTH`, 4: return-stack entries, 1 to 16.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset; same net as the ROM reset.
- `instr_data  in  24`: ROM output at its current PC; opcode [23:16], op_a [15:8], op_b [7:0].
- `zero_flag  in  1`: from the execute stage; sampled in DECODE.
- `resume  in  1`: leave HALTED when no fault is latched.
- `pc_enable  out  1`: to ROM `enable`; one-cycle advance pulse.
- `jump_enable  out  1`: to ROM `jump_enable`; one-cycle pulse.
- `jump_data  out  8`: to ROM `jump_data`.
- `issue_valid  out  1`: instruction offered to the execute stage.
- `issue_ready  in  1`: execute stage accepts.
- `issue_opcode / issue_a / issue_b  out  8 each`: fields of the latched instruction.
- `pc_mirror  out  8`: shadow of the ROM PC.
- `halted  out  1`, `fault  out  1`: status.

## Operation
- Opcodes: NOP 0x00, JMP 0x01, JZ 0x02, JNZ 0x03, CALL 0x04, RET 0x05, HALT 0xFF. Opcodes 0x06–0x0F are reserved and execute as NOP. Opcodes 0x10–0xFE are issued to the execute stage.
- States:
  - FETCH: latch `instr_data` into IR, go to DECODE.
  - DECODE: NOP or reserved → ADVANCE. JMP → JUMP. JZ → JUMP if `zero_flag`, else ADVANCE. JNZ is the inverse of JZ. CALL: if the stack is full, set `fault` and go to HALTED; otherwise push the return address and go to JUMP. RET: if the stack is empty, set `fault` and go to HALTED; otherwise pop and go to JUMP. HALT → HALTED. Any other opcode → ISSUE.
  - ISSUE: `issue_valid`=1 with fields from IR. On the cycle where `issue_valid` && `issue_ready`, go to ADVANCE. Fields stay stable while waiting.
  - ADVANCE: `pc_enable`=1; `pc_mirror` += 1, saturating at 0xFF (same rule as the ROM); go to FETCH.
  - JUMP: `jump_enable`=1. `jump_data` = op_a for JMP/JZ/JNZ/CALL and the popped address for RET. `pc_mirror` ← `jump_data`. Go to FETCH.
  - HALTED: `halted`=1. `resume` with `fault`=0 → ADVANCE. `fault` clears only on reset.
- Return address is `pc_mirror`+1, saturating at 0xFF. The stack is LIFO; the stack pointer counts 0 to `STACK_DEPTH`.
- All outputs are decoded from registered state and IR only (Moore). No combinational path from inputs to outputs.

## Timing
- Reset values: state=FETCH, IR=0, `pc_mirror`=0, stack pointer=0, and every output 0.
- Reset may assert in any state, including mid-ISSUE. The in-flight instruction is dropped with no issue and no PC change.
- `rst` must be held across at least one `clk` edge so the ROM PC clears.
- Cycles per instruction:
  - issued: 4 + ready-wait cycles.
  - NOP, taken or untaken jump, CALL, RET: 3.
  - HALT: 2 to enter HALTED; from `resume` to the next FETCH: 2.
- `pc_enable` and `jump_enable` are never high in the same cycle. Each is high for exactly one cycle per instruction.
- The ROM updates its PC at the edge that ends ADVANCE or JUMP, so `instr_data` is valid at the edge that ends FETCH.
- At `pc_mirror`=0xFF, ADVANCE still pulses `pc_enable`, and `pc_mirror` stays at 0xFF.

## Structure
- Shared package `isa_pkg`: opcode constants, field slice positions, instruction width (24), address width (8), and the state enum.
- Sub-module `return_stack`: parameterised LIFO with push, pop, full and empty, and a combinational top entry.
- Everything else lives in one FSM module.

## Test plan
- Reset, then ROM holding 0x10_AA_BB with `issue_ready` tied high. Expect `issue_valid` in cycle 3 with opcode 0x10, a 0xAA, b 0xBB. Expect `pc_enable` in cycle 4 and `pc_mirror`=1.
- JZ 0x40 with `zero_flag`=1: `jump_enable` with `jump_data`=0x40, then `pc_mirror`=0x40. Same instruction with `zero_flag`=0: `pc_enable` instead, and `pc_mirror`=1.
- CALL 0x20 at PC 5, RET at 0x20. Expect a jump to 0x20, then a jump with `jump_data`=0x06.
- Five nested CALLs with `STACK_DEPTH`=4: the fifth sets `fault` and `halted` with no `jump_enable`, and `resume` is ignored. RET on an empty stack after reset: `fault`=1.
- `issue_ready` held low for 10 cycles: `issue_valid` stays high with stable fields and no `pc_enable`. Assert `rst` mid-wait: all outputs go to 0 immediately.
- HALT at 0xFF, then `resume`: one `pc_enable` pulse and `pc_mirror` stays at 0xFF.
